demo2_waterled_pattern_master: RTL and testbench
================================================

// Module: demo2_waterled_pattern_master
// PURPOSE
//  Avalon-MM read master that fetches LED pattern words from the on-chip RAM slave (word-addressed, 32-bit).
//  Each fetched word drives the LED bank for a programmable dwell time, then the next word is fetched.
//  Sits beside the Nios II on the system interconnect. Software loads patterns into RAM, then pulses start.
// PARAMETERS
//  ADDR_W   12        word-address width of the RAM slave port
//  LED_W    18        LED bank width; led = readdata[LED_W-1:0]
//  CNT_W    26        dwell counter width
// PORTS
//  clk                input   1       system clock
//  reset              input   1       asynchronous, active-high reset
//  start              input   1       1-cycle pulse; ignored unless state==IDLE
//  stop               input   1       1-cycle pulse; request to halt the sequence
//  loop_en            input   1       1: wrap to first word after the last word; 0: finish after the last word
//  base_addr          input   ADDR_W  first word address; latched on start
//  length             input   ADDR_W  number of words; latched on start
//  dwell              input   CNT_W   cycles each word is shown; latched on start
//  avm_address        output  ADDR_W  read word address
//  avm_read           output  1       read request
//  avm_waitrequest    input   1       slave stall
//  avm_readdata       input   32      read data
//  avm_readdatavalid  input   1       read data valid
//  led                output  LED_W   current pattern
//  busy               output  1       state != IDLE
//  idx                output  ADDR_W  index of the word currently shown
//  done               output  1       1-cycle pulse on return to IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, led=0, idx=0, avm_read=0, avm_address=0, done=0, stop_pend=0.
//  FSM states: IDLE, REQ, WAIT_DATA, SHOW.
//   IDLE:
//    - start with latched length!=0 -> REQ, idx=0.
//    - start with length==0 -> stay IDLE; done pulses next cycle.
//   REQ:
//    - avm_read=1, avm_address=(base_addr+idx) mod 2^ADDR_W.
//    - Address and read are held stable while avm_waitrequest=1.
//    - Request is accepted on the first cycle with waitrequest=0 -> WAIT_DATA.
//   WAIT_DATA:
//    - avm_read=0. On avm_readdatavalid: led<=avm_readdata[LED_W-1:0], dwell counter<=0 -> SHOW.
//    - readdatavalid is accepted in the same cycle the request is accepted (zero-latency slave); the next state is then SHOW directly.
//   SHOW: the counter increments each cycle. When counter==dwell-1 (dwell==0 treated as 1):
//    - stop_pend, or (idx==length-1 and !loop_en) -> IDLE, done=1.
//    - otherwise idx<=(idx==length-1)?0:idx+1 -> REQ.
//  led is updated only on readdatavalid. In SHOW it is constant for exactly max(dwell,1) cycles.
//  Throughput: minimum period per word = dwell + 2 cycles against a 1-latency slave with no waitrequest.
//  Stop handling:
//   - In IDLE: ignored.
//   - In SHOW: immediate -> IDLE, done=1.
//   - In REQ/WAIT_DATA: sets stop_pend. The outstanding read is never abandoned; its data is loaded into led; stop takes effect at the SHOW entry cycle.
//  start while busy: ignored. start and stop in the same cycle in IDLE: start wins.
//  Address arithmetic wraps modulo 2^ADDR_W (base_addr=0xFFF, idx=1 -> 0x000).
//  Only one read is outstanding at any time; readdatavalid outside WAIT_DATA is ignored.
//  led holds its last value in IDLE; it is cleared only by reset.
// TESTING
//  T1:
//   - Stimulus: RAM[0x10..0x12]=1,2,4; base=0x10, length=3, dwell=4, loop_en=0; start.
//   - Expected: led=1,2,4, each for 4 cycles; done once; busy low after.
//  T2:
//   - Stimulus: as T1 with loop_en=1 for 10 words shown.
//   - Expected: idx sequence 0,1,2,0,1,2,0,1,2,0; led follows RAM.
//  T3:
//   - Stimulus: waitrequest held high 5 cycles on each request.
//   - Expected: avm_address/avm_read stable throughout; a single read per word.
//  T4:
//   - Stimulus: stop pulsed during WAIT_DATA of word 1.
//   - Expected: word 1 loaded into led, then IDLE, done=1; no further reads.
//  T5:
//   - Stimulus: length=0 start; then base=0xFFF, length=2.
//   - Expected: immediate done, no read; then addresses 0xFFF, 0x000.
//  T6:
//   - Stimulus: reset asserted mid-SHOW and mid-REQ.
//   - Expected: outputs at reset values in the same cycle; a new start works normally.

Source files
------------

// File: rtl/demo2_waterled_pattern_master.sv
// demo2_waterled_pattern_master
//   Avalon-MM read master that walks a table of LED pattern words in the
//   on-chip RAM. Each word is fetched, shown on the LED bank for a
//   programmable dwell time, then the next word is fetched. Software fills
//   the RAM and pulses start. The sequence either wraps (loop_en) or ends
//   after the last word.
//
// Ports
//   clk, reset         system clock, asynchronous active-high reset
//   start, stop        1-cycle control pulses (start only honoured when idle)
//   loop_en            wrap to the first word after the last one
//   base_addr, length  first word address and word count, latched on start
//   dwell              cycles each word is shown, latched on start (0 acts as 1)
//   avm_*              Avalon-MM read master port (word addressed, 32-bit)
//   led                current pattern (low LED_W bits of the fetched word)
//   busy               sequence in progress
//   idx                index of the word currently shown
//   done               1-cycle pulse on the return to idle
module demo2_waterled_pattern_master #(
  parameter int ADDR_W = 12,
  parameter int LED_W  = 18,
  parameter int CNT_W  = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [CNT_W-1:0]  dwell,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic [ADDR_W-1:0] idx,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, SHOW} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              loop_q, loop_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;
  logic [LED_W-1:0]  led_q, led_d;

  logic [CNT_W-1:0]  dwell_last;
  logic              last_word;
  logic              dwell_end;
  logic              unused_readdata;

  // Only the low LED_W bits of a fetched word drive the LEDs.
  assign unused_readdata = ^avm_readdata[31:LED_W];

  // A dwell of zero behaves like one so every word is visible for a cycle.
  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - CNT_W'(1);
  assign dwell_end  = (cnt_q == dwell_last);
  assign last_word  = (idx_q == len_q - ADDR_W'(1));

  // The request is presented straight from the state register, so address
  // and read stay stable for as long as the slave stalls.
  assign avm_read    = (state_q == REQ);
  assign avm_address = base_q + idx_q;
  assign led         = led_q;
  assign busy        = (state_q != IDLE);
  assign idx         = idx_q;
  assign done        = done_q;

  // Next-state logic. A stop seen while a read is outstanding is remembered
  // and honoured once the data has been loaded, so a read is never dropped.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    led_d       = led_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = base_addr;
          len_d       = length;
          dwell_d     = dwell;
          loop_d      = loop_en;
          stop_pend_d = 1'b0;
          if (length != '0) begin
            idx_d   = '0;
            state_d = REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      REQ: begin
        if (stop) stop_pend_d = 1'b1;
        if (!avm_waitrequest) begin
          // A zero-latency slave may return data in the accept cycle.
          if (avm_readdatavalid) begin
            led_d   = avm_readdata[LED_W-1:0];
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end

      WAIT_DATA: begin
        if (stop) stop_pend_d = 1'b1;
        if (avm_readdatavalid) begin
          led_d   = avm_readdata[LED_W-1:0];
          cnt_d   = '0;
          state_d = SHOW;
        end
      end

      SHOW: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (stop || stop_pend_q || (dwell_end && last_word && !loop_q)) begin
          stop_pend_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end else if (dwell_end) begin
          idx_d   = last_word ? '0 : idx_q + ADDR_W'(1);
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      led_q       <= led_d;
    end
  end

endmodule

// File: tb/tb_demo2_waterled_pattern_master.sv
module tb_demo2_waterled_pattern_master;

  localparam int ADDR_W = 12;
  localparam int LED_W  = 18;
  localparam int CNT_W  = 26;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, stop, loop_en;
  logic [ADDR_W-1:0] base_addr, length;
  logic [CNT_W-1:0]  dwell;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [LED_W-1:0]  led;
  logic              busy;
  logic [ADDR_W-1:0] idx;
  logic              done;

  always #5 clk = ~clk;

  demo2_waterled_pattern_master #(
    .ADDR_W(ADDR_W), .LED_W(LED_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .base_addr(base_addr), .length(length), .dwell(dwell),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .led(led), .busy(busy), .idx(idx), .done(done)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] idx;
    logic [LED_W-1:0]  led;
    int                shown;
  } word_t;

  typedef struct {
    bit                chk_idx;
    logic [ADDR_W-1:0] idx;
    logic [LED_W-1:0]  led;
  } done_t;

  word_t exp_words[$];
  done_t exp_done[$];
  int    checks   = 0;
  int    failures = 0;

  logic [31:0] ram [0:4095];
  int          wait_cycles = 0;
  int          stall_cnt   = 0;

  // RAM slave: stalls each request for wait_cycles cycles, then returns
  // the word one cycle after acceptance.
  assign avm_waitrequest = avm_read && (stall_cnt < wait_cycles);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt         <= 0;
      avm_readdatavalid <= 1'b0;
      avm_readdata      <= '0;
    end else begin
      avm_readdatavalid <= 1'b0;
      if (avm_read && avm_waitrequest) begin
        stall_cnt <= stall_cnt + 1;
      end else if (avm_read) begin
        stall_cnt         <= 0;
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= ram[avm_address];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] i,
                          input logic [LED_W-1:0] l, input int s);
    word_t w;
    w.addr = a; w.idx = i; w.led = l; w.shown = s;
    exp_words.push_back(w);
  endtask

  task automatic pushDone(input bit c, input logic [ADDR_W-1:0] i,
                          input logic [LED_W-1:0] l);
    done_t d;
    d.chk_idx = c; d.idx = i; d.led = l;
    exp_done.push_back(d);
  endtask

  // Called at a negedge; start is high across exactly one rising edge.
  task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                               input logic [CNT_W-1:0] d, input logic lp, input int w);
    wait_cycles = w;
    base_addr   = b;
    length      = l;
    dwell       = d;
    loop_en     = lp;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic waitAccept(input string name, input logic [ADDR_W-1:0] addr,
                            input bit any_addr, input int budget);
    int n = 0;
    bit found;
    found = avm_read && !avm_waitrequest && (any_addr || avm_address == addr);
    while (!found && n < budget) begin
      @(negedge clk);
      n++;
      found = avm_read && !avm_waitrequest && (any_addr || avm_address == addr);
    end
    checkOutput({name, "_accept_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput({name, "_words_left"}, exp_words.size(), 32'd0);
    checkOutput({name, "_done_left"}, exp_done.size(), 32'd0);
    checkOutput({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_led"},      {14'd0, led},         32'd0);
    checkOutput({name, "_busy"},     {31'd0, busy},        32'd0);
    checkOutput({name, "_avm_read"}, {31'd0, avm_read},    32'd0);
    checkOutput({name, "_avm_addr"}, {20'd0, avm_address}, 32'd0);
    checkOutput({name, "_idx"},      {20'd0, idx},         32'd0);
    checkOutput({name, "_done"},     {31'd0, done},        32'd0);
  endtask

  // Monitor: pops an expected word on every accepted read, then measures
  // how many cycles that word is shown; pops an expected entry on done.
  initial begin
    int    mon_state = 0;
    int    shown = 0;
    bit    led_ok = 1'b1;
    bit    prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    word_t cur;
    done_t d;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_state  = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("stall_read_held", {31'd0, avm_read}, 32'd1);
          checkOutput("stall_addr_held", {20'd0, avm_address}, {20'd0, prev_addr});
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;

        if (mon_state == 2) begin
          if (busy && !avm_read) begin
            shown++;
            if (led !== cur.led) led_ok = 1'b0;
          end else begin
            checkOutput("word_shown_cycles", shown, cur.shown);
            checkOutput("word_led_value", {31'd0, led_ok}, 32'd1);
            mon_state = 0;
          end
        end

        if (avm_read && !avm_waitrequest) begin
          if (exp_words.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_read actual_addr=0x%0h required=no_read", avm_address);
          end else begin
            cur = exp_words.pop_front();
            checkOutput("read_addr", {20'd0, avm_address}, {20'd0, cur.addr});
            checkOutput("read_idx", {20'd0, idx}, {20'd0, cur.idx});
            shown     = 0;
            led_ok    = 1'b1;
            mon_state = 1;
          end
        end else if (mon_state == 1) begin
          mon_state = 2;
        end

        if (done) begin
          if (exp_done.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done actual=1 required=0");
          end else begin
            d = exp_done.pop_front();
            checkOutput("done_led", {14'd0, led}, {14'd0, d.led});
            checkOutput("done_busy", {31'd0, busy}, 32'd0);
            if (d.chk_idx) checkOutput("done_idx", {20'd0, idx}, {20'd0, d.idx});
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    loop_en   = 1'b0;
    base_addr = '0;
    length    = '0;
    dwell     = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    ram[12'h010] = 32'hA5A0_0001;
    ram[12'h011] = 32'h5A50_0002;
    ram[12'h012] = 32'hFFC0_0004;
    ram[12'hFFF] = 32'hABCF_FFFF;
    ram[12'h000] = 32'hFFF1_2345;

    repeat (2) @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] T1 single pass");
    pushWord(12'h010, 12'd0, 18'h1, 4);
    pushWord(12'h011, 12'd1, 18'h2, 4);
    pushWord(12'h012, 12'd2, 18'h4, 4);
    pushDone(1'b1, 12'd2, 18'h4);
    applyStimulus(12'h010, 12'd3, 26'd4, 1'b0, 0);
    waitIdle("t1", 200);

    $display("[TB] T2 looping");
    for (int i = 0; i < 10; i++) begin
      logic [LED_W-1:0] l;
      l = (i % 3 == 0) ? 18'h1 : (i % 3 == 1) ? 18'h2 : 18'h4;
      pushWord(12'h010 + ADDR_W'(i % 3), ADDR_W'(i % 3), l, 4);
    end
    pushDone(1'b1, 12'd0, 18'h1);
    applyStimulus(12'h010, 12'd3, 26'd4, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      waitAccept("t2", 12'h0, 1'b1, 50);
    end
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    waitIdle("t2", 50);

    $display("[TB] T3 waitrequest stalls");
    pushWord(12'h010, 12'd0, 18'h1, 2);
    pushWord(12'h011, 12'd1, 18'h2, 2);
    pushWord(12'h012, 12'd2, 18'h4, 2);
    pushDone(1'b1, 12'd2, 18'h4);
    applyStimulus(12'h010, 12'd3, 26'd2, 1'b0, 5);
    waitIdle("t3", 200);

    $display("[TB] T4 stop during data wait");
    pushWord(12'h010, 12'd0, 18'h1, 3);
    pushWord(12'h011, 12'd1, 18'h2, 1);
    pushDone(1'b1, 12'd1, 18'h2);
    applyStimulus(12'h010, 12'd3, 26'd3, 1'b0, 0);
    waitAccept("t4", 12'h011, 1'b0, 50);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    waitIdle("t4", 50);

    $display("[TB] T5 zero length and address wrap");
    pushDone(1'b0, 12'd0, 18'h2);
    applyStimulus(12'h000, 12'd0, 26'd4, 1'b0, 0);
    checkOutput("t5_len0_done", {31'd0, done}, 32'd1);
    checkOutput("t5_len0_busy", {31'd0, busy}, 32'd0);
    waitIdle("t5a", 5);
    pushWord(12'hFFF, 12'd0, 18'h3FFFF, 1);
    pushWord(12'h000, 12'd1, 18'h12345, 1);
    pushDone(1'b1, 12'd1, 18'h12345);
    applyStimulus(12'hFFF, 12'd2, 26'd0, 1'b0, 0);
    waitIdle("t5b", 50);

    $display("[TB] T6 reset mid-sequence");
    pushWord(12'h010, 12'd0, 18'h1, 6);
    applyStimulus(12'h010, 12'd3, 26'd6, 1'b0, 0);
    waitAccept("t6_show", 12'h010, 1'b0, 20);
    repeat (3) @(negedge clk);
    checkOutput("t6_in_show_led", {14'd0, led}, 32'h1);
    #2 reset = 1'b1;
    #1 checkResetState("t6_show_rst");
    exp_words.delete();
    exp_done.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    applyStimulus(12'h010, 12'd3, 26'd4, 1'b0, 5);
    repeat (2) @(negedge clk);
    checkOutput("t6_in_req_read", {31'd0, avm_read}, 32'd1);
    #2 reset = 1'b1;
    #1 checkResetState("t6_req_rst");
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    pushWord(12'h010, 12'd0, 18'h1, 4);
    pushWord(12'h011, 12'd1, 18'h2, 4);
    pushWord(12'h012, 12'd2, 18'h4, 4);
    pushDone(1'b1, 12'd2, 18'h4);
    applyStimulus(12'h010, 12'd3, 26'd4, 1'b0, 0);
    waitIdle("t6_restart", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
